// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit teaching CPU.
// Opcodes, instruction field positions, default widths and fetch FSM states.
package cpu_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 8;

    localparam logic [1:0] OP_RTYPE = 2'b00;
    localparam logic [1:0] OP_LW    = 2'b01;
    localparam logic [1:0] OP_SW    = 2'b10;
    localparam logic [1:0] OP_BEQ   = 2'b11;

    localparam int OP_HI = 7;
    localparam int OP_LO = 6;
    localparam int RS_HI = 5;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 2;
    localparam int RD_HI = 1;
    localparam int RD_LO = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetchState_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, stall-hold and flush.
// An empty slot always reads as all-zero so a bubble decodes as op 00.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic               hold,
    input  logic [INSTR_W-1:0] instrD,
    input  logic [PC_W-1:0]    pcPlus1D,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pcPlus1
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid   <= 1'b0;
            instr   <= '0;
            pcPlus1 <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= instrD;
            pcPlus1 <= pcPlus1D;
        end else if (!hold) begin
            // consumed by decode with nothing new behind it
            valid   <= 1'b0;
            instr   <= '0;
            pcPlus1 <= '0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with req/valid imem handshake, skid buffer and IF/ID.
// Define FETCH_PERF_EN to add perf_fetched / perf_bubbles counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc_plus1,
    output logic [1:0]         op,
    output logic [1:0]         rs,
    output logic [1:0]         rt,
    output logic [1:0]         rd
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_bubbles
`endif
);

    fetchState_t        state, stateNext;
    logic [PC_W-1:0]    pc, pcNext, pcInc;
    logic               reqNext;
    logic [PC_W-1:0]    addrNext;
    logic               kill, killNext;
    logic               skidValid, skidValidNext;
    logic [INSTR_W-1:0] skidInstr, skidNext;
    logic               idLoad, idFlush;
    logic [INSTR_W-1:0] idInstr;
    logic               outstanding, done;

    assign pcInc       = pc + PC_W'(1);
    assign outstanding = imem_req && !imem_valid;
    assign done        = imem_req && imem_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            kill      <= 1'b0;
            skidValid <= 1'b0;
            skidInstr <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            imem_req  <= reqNext;
            imem_addr <= addrNext;
            kill      <= killNext;
            skidValid <= skidValidNext;
            skidInstr <= skidNext;
        end
    end

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        reqNext       = imem_req;
        addrNext      = imem_addr;
        killNext      = kill;
        skidValidNext = skidValid;
        skidNext      = skidInstr;
        idLoad        = 1'b0;
        idFlush       = 1'b0;
        idInstr       = imem_rdata;
        if (branch_taken) begin
            idFlush       = 1'b1;
            skidValidNext = 1'b0;
            pcNext        = branch_target;
            stateNext     = S_FETCH;
            reqNext       = 1'b1;
            // an in-flight request must finish at its own address first
            if (outstanding) begin
                killNext = 1'b1;
            end else begin
                killNext = 1'b0;
                addrNext = branch_target;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    stateNext = S_FETCH;
                    reqNext   = 1'b1;
                    addrNext  = pc;
                end
                S_FETCH: begin
                    if (done) begin
                        if (kill) begin
                            killNext = 1'b0;
                            addrNext = pc;
                        end else if (!stall || !if_valid) begin
                            idLoad   = 1'b1;
                            pcNext   = pcInc;
                            addrNext = pcInc;
                        end else begin
                            skidValidNext = 1'b1;
                            skidNext      = imem_rdata;
                            reqNext       = 1'b0;
                            stateNext     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall && skidValid) begin
                        idLoad        = 1'b1;
                        idInstr       = skidInstr;
                        skidValidNext = 1'b0;
                        pcNext        = pcInc;
                        addrNext      = pcInc;
                        reqNext       = 1'b1;
                        stateNext     = S_FETCH;
                    end
                end
                default: stateNext = S_IDLE;
            endcase
        end
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) uIfId (
        .clk      (clk),
        .reset    (reset),
        .load     (idLoad),
        .flush    (idFlush),
        .hold     (stall),
        .instrD   (idInstr),
        .pcPlus1D (pcInc),
        .valid    (if_valid),
        .instr    (if_instr),
        .pcPlus1  (if_pc_plus1)
    );

    assign op = if_instr[OP_HI:OP_LO];
    assign rs = if_instr[RS_HI:RS_LO];
    assign rt = if_instr[RT_HI:RT_LO];
    assign rd = if_instr[RD_HI:RD_LO];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (idLoad && perf_fetched != 16'hFFFF)
                perf_fetched <= perf_fetched + 16'd1;
            if (!if_valid && perf_bubbles != 16'hFFFF)
                perf_bubbles <= perf_bubbles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch, stall/skid, branch kill,
// branch+valid collision, PC wrap and reset during hold.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid = 1'b0;
    logic [7:0] imem_rdata = 8'h00;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       if_valid;
    logic [7:0] if_instr;
    logic [7:0] if_pc_plus1;
    logic [1:0] op, rs, rt, rd;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched, perf_bubbles;
`endif

    int checks = 0;
    int errs = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc_plus1   (if_pc_plus1),
        .op            (op),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errs++; $display("FAIL rst_addr got=%h exp=00", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        checks++; if ({if_instr, if_pc_plus1} !== 16'h0000) begin errs++; $display("FAIL rst_ifid got=%h/%h exp=00/00", if_instr, if_pc_plus1); end
        checks++; if ({op, rs, rt, rd} !== 8'h00) begin errs++; $display("FAIL rst_fields got=%h exp=00", {op, rs, rt, rd}); end
        reset = 1'b0;
    endtask

    task automatic test_fetch;
        tick();
        checks++; if ({imem_req, imem_addr} !== 9'h100) begin errs++; $display("FAIL f_addr0 got=%b/%h exp=1/00", imem_req, imem_addr); end
        imem_valid = 1'b1; imem_rdata = 8'h4D;
        tick();
        checks++; if (imem_addr !== 8'h01) begin errs++; $display("FAIL f_addr1 got=%h exp=01", imem_addr); end
        checks++; if ({if_valid, op, rs, rt, rd} !== {1'b1, 2'b01, 2'b00, 2'b11, 2'b01}) begin errs++; $display("FAIL f_fields1 got=%b%b%b%b%b exp=1_01_00_11_01", if_valid, op, rs, rt, rd); end
        checks++; if (if_pc_plus1 !== 8'h01) begin errs++; $display("FAIL f_pcp1_1 got=%h exp=01", if_pc_plus1); end
        imem_rdata = 8'h91;
        tick();
        checks++; if (imem_addr !== 8'h02) begin errs++; $display("FAIL f_addr2 got=%h exp=02", imem_addr); end
        checks++; if ({op, if_instr} !== {2'b10, 8'h91}) begin errs++; $display("FAIL f_instr2 got=%b/%h exp=10/91", op, if_instr); end
        checks++; if (if_pc_plus1 !== 8'h02) begin errs++; $display("FAIL f_pcp1_2 got=%h exp=02", if_pc_plus1); end
`ifdef FETCH_PERF_EN
        checks++; if ({perf_fetched, perf_bubbles} !== {16'd2, 16'd2}) begin errs++; $display("FAIL f_perf got=%0d/%0d exp=2/2", perf_fetched, perf_bubbles); end
`endif
    endtask

    task automatic test_stall_skid;
        stall = 1'b1; imem_valid = 1'b1; imem_rdata = 8'hA7;
        tick();
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({imem_req, if_valid, if_instr} !== {1'b0, 1'b1, 8'h91}) begin errs++; $display("FAIL s_hold%0d got=%b/%b/%h exp=0/1/91", i, imem_req, if_valid, if_instr); end
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        checks++; if ({if_valid, if_instr, if_pc_plus1} !== {1'b1, 8'hA7, 8'h03}) begin errs++; $display("FAIL s_release got=%b/%h/%h exp=1/a7/03", if_valid, if_instr, if_pc_plus1); end
        checks++; if ({imem_req, imem_addr} !== 9'h103) begin errs++; $display("FAIL s_next got=%b/%h exp=1/03", imem_req, imem_addr); end
    endtask

    task automatic test_branch_kill;
        imem_valid = 1'b1; imem_rdata = 8'h00;
        tick();
        tick();
        checks++; if (imem_addr !== 8'h05) begin errs++; $display("FAIL b_pre got=%h exp=05", imem_addr); end
        imem_valid = 1'b0; stall = 1'b1;
        branch_taken = 1'b1; branch_target = 8'h20;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        checks++; if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h05}) begin errs++; $display("FAIL b_flush got=%b/%b/%h exp=0/1/05", if_valid, imem_req, imem_addr); end
        tick();
        imem_valid = 1'b1; imem_rdata = 8'hFF;
        tick();
        checks++; if ({if_valid, imem_addr} !== {1'b0, 8'h20}) begin errs++; $display("FAIL b_drop got=%b/%h exp=0/20", if_valid, imem_addr); end
        imem_rdata = 8'hC6;
        tick();
        checks++; if ({if_valid, if_instr, if_pc_plus1, imem_addr} !== {1'b1, 8'hC6, 8'h21, 8'h21}) begin errs++; $display("FAIL b_target got=%b/%h/%h/%h exp=1/c6/21/21", if_valid, if_instr, if_pc_plus1, imem_addr); end
    endtask

    task automatic test_branch_same_cycle;
        stall = 1'b1; imem_valid = 1'b1; imem_rdata = 8'h3C;
        branch_taken = 1'b1; branch_target = 8'hFE;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        checks++; if ({if_valid, if_instr} !== {1'b0, 8'h00}) begin errs++; $display("FAIL c_flush got=%b/%h exp=0/00", if_valid, if_instr); end
        checks++; if ({imem_req, imem_addr} !== 9'h1FE) begin errs++; $display("FAIL c_addr got=%b/%h exp=1/fe", imem_req, imem_addr); end
        imem_rdata = 8'h12;
        tick();
        checks++; if ({if_valid, if_instr, if_pc_plus1, imem_addr} !== {1'b1, 8'h12, 8'hFF, 8'hFF}) begin errs++; $display("FAIL c_nokill got=%b/%h/%h/%h exp=1/12/ff/ff", if_valid, if_instr, if_pc_plus1, imem_addr); end
    endtask

    task automatic test_pc_wrap;
        imem_rdata = 8'h34;
        tick();
        checks++; if ({if_instr, if_pc_plus1, imem_addr} !== {8'h34, 8'h00, 8'h00}) begin errs++; $display("FAIL w_wrap got=%h/%h/%h exp=34/00/00", if_instr, if_pc_plus1, imem_addr); end
    endtask

    task automatic test_reset_in_hold;
        stall = 1'b1; imem_valid = 1'b1; imem_rdata = 8'h55;
        tick();
        imem_valid = 1'b0;
        checks++; if ({imem_req, if_instr} !== {1'b0, 8'h34}) begin errs++; $display("FAIL r_hold got=%b/%h exp=0/34", imem_req, if_instr); end
        reset = 1'b1;
        tick();
        checks++; if ({imem_req, imem_addr, if_valid} !== {1'b0, 8'h00, 1'b0}) begin errs++; $display("FAIL r_ctl got=%b/%h/%b exp=0/00/0", imem_req, imem_addr, if_valid); end
        checks++; if ({if_instr, if_pc_plus1, op, rs, rt, rd} !== 24'h0) begin errs++; $display("FAIL r_ifid got=%h/%h exp=00/00", if_instr, if_pc_plus1); end
`ifdef FETCH_PERF_EN
        checks++; if ({perf_fetched, perf_bubbles} !== 32'h0) begin errs++; $display("FAIL r_perf got=%0d/%0d exp=0/0", perf_fetched, perf_bubbles); end
`endif
        reset = 1'b0; stall = 1'b0;
        tick();
        checks++; if ({imem_req, imem_addr, if_valid} !== {1'b1, 8'h00, 1'b0}) begin errs++; $display("FAIL r_restart got=%b/%h/%b exp=1/00/0", imem_req, imem_addr, if_valid); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall_skid();
        test_branch_kill();
        test_branch_same_cycle();
        test_pc_wrap();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch and IF/ID register for the 8-bit teaching CPU.
- Holds the PC and fetches from instruction memory over a req/valid handshake.
- Registers the instruction and splits it into fields; op[1:0] drives the main control decoder directly.
- Handles decode stall, branch redirect/flush and cancellation of an in-flight fetch.

Parameters:
- PC_W, 8, PC and instruction-address width.
- INSTR_W, 8, instruction width. Fields: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_valid.
- imem_addr  out  PC_W  fetch address; stable while imem_req=1 and imem_valid=0.
- imem_valid  in  1  read data valid; completes the current request (may be asserted in the same cycle as req).
- imem_rdata  in  INSTR_W  instruction word.
- stall  in  1  decode cannot accept; hold IF/ID.
- branch_taken  in  1  redirect to branch_target; flush IF/ID.
- branch_target  in  PC_W  redirect address.
- if_valid  out  1  IF/ID holds a real instruction.
- if_instr  out  INSTR_W  registered instruction.
- if_pc_plus1  out  PC_W  address of if_instr + 1, for branch adder.
- op  out  2  if_instr[7:6]; feeds control decoder.
- rs, rt, rd  out  2 each  register fields.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC, kill=0, skid empty, if_valid=0, if_instr=0, if_pc_plus1=0, so op/rs/rt/rd=0.
- Bubbles: decode must qualify RegWrite, MemWrite and Branch with if_valid. A bubble decodes as op 00 (R-type) and is not safe ungated.
- All outputs are registered. Fetch latency is 1 cycle from the imem_valid edge to if_valid.
- FSM states: S_IDLE, S_FETCH, S_HOLD.
- S_IDLE: go to S_FETCH next cycle with imem_req=1, imem_addr=pc.
- S_FETCH, imem_valid=1, kill=0, no branch, IF/ID free (!stall or !if_valid):
  - if_instr<=rdata, if_pc_plus1<=pc+1, if_valid<=1, pc<=pc+1.
  - Next request addr=pc+1; stay in S_FETCH.
- S_FETCH, imem_valid=1, stall=1 and if_valid=1:
  - Word goes to a 1-entry skid buffer; imem_req<=0; go to S_HOLD.
- S_FETCH, imem_valid=0, stall=1 while IF/ID already holds a valid instruction: no effect, the request stays pending.
- S_HOLD: on !stall, skid moves to IF/ID, pc<=pc+1, go to S_FETCH.
- branch_taken (any state; priority over stall and valid):
  - if_valid<=0, skid dropped, pc<=branch_target.
  - If a request is outstanding (req=1, valid=0): kill<=1, addr held until that request completes.
  - Otherwise the next request uses branch_target. State becomes S_FETCH.
- kill=1 and imem_valid=1: word discarded, kill<=0, next request addr=pc (the target).
- branch_taken with imem_valid in the same cycle: word discarded, kill stays 0, next request addr=branch_target.
- pc arithmetic is modulo 2^PC_W. Wrap 0xFF to 0x00 is legal and silent.
- Reset mid-fetch returns everything to reset values. Instruction memory shares the same reset, so no stale response arrives.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[15:0] and perf_bubbles[15:0], both saturating at 0xFFFF and reset to 0.
  - perf_fetched increments per instruction loaded into IF/ID.
  - perf_bubbles increments per cycle with if_valid=0 and not in reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- cpu_pkg holds:
  - opcode constants OP_RTYPE=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_BEQ=2'b11;
  - field bit positions;
  - default PC_W/INSTR_W;
  - fetch FSM state enum.
- Sub-module if_id_reg: IF/ID register with load, stall-hold and flush; no other logic.

Test Plan:
- Reset then zero-wait memory returning 8'h4D, 8'h91: imem_addr 00, 01, 02 on consecutive cycles; op=01, rs=00, rt=11, rd=01 then op=10; if_pc_plus1 01 then 02.
- stall held for 3 cycles while a word arrives: word kept in skid, imem_req=0, IF/ID unchanged; on release the skid word loads and the next addr is +1.
- branch_taken with target 0x20 while a request to 0x05 is outstanding with 2-cycle latency: if_valid=0 next cycle; the 0x05 data is dropped; next request addr=0x20.
- branch_taken and imem_valid in the same cycle with stall=1: word dropped, IF/ID flushed, next addr=target.
- pc=0xFF fetch: next addr=0x00, if_pc_plus1=0x00.
- Reset asserted mid-S_HOLD: all outputs return to reset values the next cycle; FETCH_PERF_EN counters read 0.
